// File: rtl/sym_serial_tx_if.sv
// Symbol handshake bundle between a symbol producer and sym_serial_tx.
//   sym_in    [1:0] : symbol to send (11, 10, 01; 00 is flagged and dropped)
//   sym_valid       : sym_in is valid this cycle
//   sym_ready       : transmitter can accept a symbol this cycle
interface sym_serial_tx_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_in, output sym_valid, input sym_ready);
    modport slave  (input sym_in, input sym_valid, output sym_ready);
endinterface

// File: rtl/sym_serial_tx.sv
// Serial symbol transmitter for the run-length line code.
// Symbols are buffered in a small FIFO and sent as a run of zeros followed by
// a closing one; the idle-high line level serves as the leading one.
//   clk, rst  : clock, synchronous active-high reset
//   sym_if    : symbol handshake (slave side)
//   x_out     : registered serial line, idles high
//   sym_sent  : registered pulse during a symbol's closing one
//   err_zero  : registered pulse the cycle after a 00 symbol is accepted
//   busy      : registered, high while the FIFO holds symbols or a symbol is on the line
module sym_serial_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LONG_ZEROS = 3
) (
    input  logic            clk,
    input  logic            rst,
    sym_serial_tx_if.slave  sym_if,
    output logic            x_out,
    output logic            sym_sent,
    output logic            err_zero,
    output logic            busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(LONG_ZEROS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZERO = 2'd1,
        ST_MARK = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   zcnt_q, zcnt_d;
    logic               x_out_q, x_out_d;
    logic               sym_sent_q, sym_sent_d;
    logic               err_zero_q, err_zero_d;
    logic               busy_q, busy_d;

    logic               full;
    logic               fifo_nonempty;
    logic               accept;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   head_len;

    // Handshake and FIFO control
    assign full             = (count_q == OCC_W'(FIFO_DEPTH));
    assign fifo_nonempty    = (count_q != '0);
    assign sym_if.sym_ready = !full && !rst;
    assign accept           = sym_if.sym_valid && sym_if.sym_ready;
    assign push             = accept && (sym_if.sym_in != 2'b00);
    // A new symbol can only start when no zero run is in progress
    assign pop              = ((state_q == ST_IDLE) || (state_q == ST_MARK)) && fifo_nonempty;

    // Zero-run length of the symbol at the FIFO head
    always_comb begin
        head_len = CNT_W'(LONG_ZEROS);
        case (mem_q[rd_ptr_q])
            2'b11:   head_len = CNT_W'(1);
            2'b10:   head_len = CNT_W'(2);
            default: head_len = CNT_W'(LONG_ZEROS);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fifo_nonempty) state_d = ST_ZERO;
            ST_ZERO: if (zcnt_q <= CNT_W'(1)) state_d = ST_MARK;
            ST_MARK: state_d = fifo_nonempty ? ST_ZERO : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so they land registered
    always_comb begin
        x_out_d    = (state_d != ST_ZERO);
        sym_sent_d = (state_d == ST_MARK);
        err_zero_d = accept && (sym_if.sym_in == 2'b00);
        busy_d     = (count_d != '0) || (state_d != ST_IDLE);
    end

    // FIFO pointers, occupancy and zero-run counter
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        zcnt_d = zcnt_q;
        if (pop) begin
            zcnt_d = head_len;
        end else if ((state_q == ST_ZERO) && (zcnt_q != '0)) begin
            zcnt_d = zcnt_q - CNT_W'(1);
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            zcnt_q     <= '0;
            x_out_q    <= 1'b1;
            sym_sent_q <= 1'b0;
            err_zero_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            zcnt_q     <= zcnt_d;
            x_out_q    <= x_out_d;
            sym_sent_q <= sym_sent_d;
            err_zero_q <= err_zero_d;
            busy_q     <= busy_d;
        end
    end

    // Symbol storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sym_if.sym_in;
        end
    end

    assign x_out    = x_out_q;
    assign sym_sent = sym_sent_q;
    assign err_zero = err_zero_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sym_serial_tx.sv
// Self-checking bench for sym_serial_tx: directed table, corner sequences and
// random traffic checked against a symbol-stream reference model.
module tb_sym_serial_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LZ    = 3;

    logic clk;
    logic rst;
    logic x_out, sym_sent, err_zero, busy;

    sym_serial_tx_if sif();

    sym_serial_tx #(.FIFO_DEPTH(DEPTH), .LONG_ZEROS(LZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .sym_if   (sif),
        .x_out    (x_out),
        .sym_sent (sym_sent),
        .err_zero (err_zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: queue of waiting symbols plus the queue of line slots
    // still to be shown for the symbol being transmitted.
    typedef struct packed {
        logic       x;
        logic       sent;
        logic [1:0] sym;
    } slot_t;

    logic [1:0] symq[$];
    slot_t      pend[$];
    slot_t      disp;
    logic       m_err;

    // Receiver-side decode of the DUT's line
    int zero_run;

    // Last sampled DUT values
    logic       got_ready;
    logic [3:0] got_out;

    function automatic slot_t idle_slot();
        slot_t t;
        t.x = 1'b1; t.sent = 1'b0; t.sym = 2'b00;
        return t;
    endfunction

    function automatic logic m_ready(logic r);
        return !r && (symq.size() < DEPTH);
    endfunction

    function automatic logic m_busy();
        return (symq.size() != 0) || (disp.x == 1'b0) || disp.sent;
    endfunction

    function automatic logic [1:0] decode(int run);
        if (run == 1) return 2'b11;
        if (run == 2) return 2'b10;
        if (run == int'(LZ)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic m_step(logic r, logic v, logic [1:0] s);
        logic       acc;
        logic [1:0] h;
        int         n;
        slot_t      t;
        acc = v && m_ready(r);
        if (r) begin
            symq.delete();
            pend.delete();
            disp  = idle_slot();
            m_err = 1'b0;
            return;
        end
        if (pend.size() == 0 && symq.size() > 0) begin
            h = symq.pop_front();
            n = (h == 2'b11) ? 1 : (h == 2'b10) ? 2 : int'(LZ);
            for (int i = 0; i < n; i++) begin
                t.x = 1'b0; t.sent = 1'b0; t.sym = 2'b00;
                pend.push_back(t);
            end
            t.x = 1'b1; t.sent = 1'b1; t.sym = h;
            pend.push_back(t);
        end
        if (acc && s != 2'b00) symq.push_back(s);
        m_err = acc && (s == 2'b00);
        disp  = (pend.size() != 0) ? pend.pop_front() : idle_slot();
    endtask

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check ready before the edge, step the model,
    // check registered outputs after the edge.
    task automatic cycle(logic r, logic v, logic [1:0] s);
        logic [3:0] exp_out;
        rst           = r;
        sif.sym_valid = v;
        sif.sym_in    = s;
        #1;
        got_ready = sif.sym_ready;
        check("sym_ready", 8'(got_ready), 8'(m_ready(r)));
        @(posedge clk);
        m_step(r, v, s);
        #1;
        got_out = {x_out, sym_sent, err_zero, busy};
        exp_out = {disp.x, disp.sent, m_err, m_busy()};
        check("x/sent/err/busy", 8'(got_out), 8'(exp_out));
        if (r) begin
            zero_run = 0;
        end else if (x_out == 1'b0) begin
            zero_run++;
        end else begin
            if (sym_sent && disp.sent)
                check("rx_decode", 8'(decode(zero_run)), 8'(disp.sym));
            zero_run = 0;
        end
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] s;
        logic       x;
        logic       sent;
        logic       err;
        logic       bsy;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic r, logic v, logic [1:0] s,
                       logic x, logic sent, logic err, logic bsy, logic rdy);
        vec_t e;
        e.r = r; e.v = v; e.s = s;
        e.x = x; e.sent = sent; e.err = err; e.bsy = bsy; e.rdy = rdy;
        tbl.push_back(e);
    endtask

    int xfers;

    initial begin
        vectors     = 0;
        miscompares = 0;
        zero_run    = 0;
        disp        = idle_slot();
        m_err       = 1'b0;
        rst           = 1'b1;
        sif.sym_valid = 1'b0;
        sif.sym_in    = 2'b00;

        // Reset for 3 cycles, then one idle cycle
        for (int i = 0; i < 3; i++) add(1, 0, 2'b00, 1, 0, 0, 0, 0);
        add(0, 0, 2'b00, 1, 0, 0, 0, 1);
        // Back-to-back 11,10,01,11: line 0,1,0,0,1,0,0,0,1,0,1
        add(0, 1, 2'b11, 1, 0, 0, 1, 1);
        add(0, 1, 2'b10, 0, 0, 0, 1, 1);
        add(0, 1, 2'b01, 1, 1, 0, 1, 1);
        add(0, 1, 2'b11, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 1, 1, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 1, 1, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 1, 1, 0, 1, 1);
        add(0, 0, 2'b00, 1, 0, 0, 0, 1);
        // 10, 00, 10: one err_zero pulse, line carries only the two 10s
        add(0, 1, 2'b10, 1, 0, 0, 1, 1);
        add(0, 1, 2'b00, 0, 0, 1, 1, 1);
        add(0, 1, 2'b10, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 1, 1, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 0, 0, 0, 1, 1);
        add(0, 0, 2'b00, 1, 1, 0, 1, 1);
        add(0, 0, 2'b00, 1, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].s);
            check("tbl_ready", 8'(got_ready), 8'(tbl[i].rdy));
            check("tbl_out", 8'(got_out),
                  8'({tbl[i].x, tbl[i].sent, tbl[i].err, tbl[i].bsy}));
        end

        // Single symbols with idle gaps
        cycle(0, 1, 2'b11); repeat (5) cycle(0, 0, 2'b00);
        cycle(0, 1, 2'b10); repeat (6) cycle(0, 0, 2'b00);
        cycle(0, 1, 2'b01); repeat (7) cycle(0, 0, 2'b00);

        // Full FIFO: hold 01 valid for 6 cycles
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 2'b01);
            if (got_ready) xfers++;
        end
        check("full_xfers", 8'(xfers), 8'd5);
        repeat (30) cycle(0, 0, 2'b00);
        check("full_drained_busy", 8'(busy), 8'd0);

        // Reset during the second zero of a 01 with two symbols queued
        cycle(0, 1, 2'b01);
        cycle(0, 1, 2'b01);
        cycle(0, 1, 2'b01);
        cycle(1, 0, 2'b00);
        check("midrst_x", 8'(x_out), 8'd1);
        check("midrst_busy", 8'(busy), 8'd0);
        repeat (8) cycle(0, 0, 2'b00);

        // Random traffic with occasional 00 symbols and resets
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic       v;
            logic [1:0] s;
            int         k;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 2) != 0);
            k = $urandom_range(0, 9);
            s = (k == 0) ? 2'b00 : 2'(1 + (k % 3));
            cycle(r, v, s);
        end
        repeat (20) cycle(0, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
